// File: rtl/sipo_scan_buf.sv
// sipo_scan_buf
//   Serial-in scan capture buffer with parallel read-out.
//   A capture shifts LANES bits per clock into a word assembler and stores
//   each completed word into an internal memory.
//   A read streams the stored words out on pout, one word per clock.
//
//   state | meaning
//   IDLE  | waiting for val_op; op/op_len latched on the accepting edge
//   SCAN  | sampling sin every edge, writing completed words to memory
//   READ  | loading one stored word per edge onto pout
//   DONE  | single completion cycle (op_commit), then back to IDLE
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-high reset
//   sin        in   [LANES]  serial scan data
//   pout       out  [WIDTH]  registered read word
//   pout_val   out  pout holds a valid read word
//   val_op     in   operation request (accepted in IDLE only)
//   op         in   0 = scan capture, 1 = read out
//   op_len     in   [AW] words to capture/read, 0 or > DEPTH means DEPTH
//   op_abort   in   abort a running SCAN/READ
//   scaning    out  capture in progress
//   op_ack     out  one-cycle request-accepted pulse
//   op_commit  out  one-cycle completion pulse
//   op_err     out  one-cycle abort pulse
//   fill_cnt   out  [AW] words held from the last capture
module sipo_scan_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    parameter int LANES = 1,
    localparam int AW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [LANES-1:0] sin,
    output logic [WIDTH-1:0] pout,
    output logic             pout_val,
    input  logic             val_op,
    input  logic             op,
    input  logic [AW-1:0]    op_len,
    input  logic             op_abort,
    output logic             scaning,
    output logic             op_ack,
    output logic             op_commit,
    output logic             op_err,
    output logic [AW-1:0]    fill_cnt
);

    localparam int SPW = WIDTH / LANES;
    localparam int BCW = (SPW > 1) ? $clog2(SPW) : 1;
    localparam int MAW = $clog2(DEPTH);
    localparam logic [AW-1:0]  DEPTH_L  = AW'(DEPTH);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(SPW - 1);

    typedef enum logic [1:0] {IDLE, SCAN, READ, DONE} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     len_q, len_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [AW-1:0]     widx_q, widx_d;
    logic [AW-1:0]     fill_q, fill_d;
    logic [WIDTH-1:0]  pout_q, pout_d;
    logic              pval_q, pval_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic              mem_we;
    logic [WIDTH-1:0]  shifted;
    logic [AW-1:0]     eff_len;
    logic              last_word;
    logic              word_done;

    always_comb begin
        shifted   = (shift_q << LANES) | WIDTH'(sin);
        last_word = (widx_q == (len_q - AW'(1)));
        word_done = (bit_cnt_q == '0);
        if (op_len == '0 || op_len > DEPTH_L) begin
            eff_len = DEPTH_L;
        end else begin
            eff_len = op_len;
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        widx_d    = widx_q;
        fill_d    = fill_q;
        pout_d    = pout_q;
        pval_d    = pval_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        mem_we    = 1'b0;

        case (state_q)
            IDLE: begin
                pval_d = 1'b0;
                if (val_op) begin
                    ack_d     = 1'b1;
                    widx_d    = '0;
                    bit_cnt_d = BIT_LAST;
                    shift_d   = '0;
                    if (op) begin
                        // Reads never run past what the last capture stored.
                        len_d   = (fill_q < eff_len) ? fill_q : eff_len;
                        state_d = READ;
                    end else begin
                        len_d   = eff_len;
                        state_d = SCAN;
                    end
                end
            end

            SCAN: begin
                shift_d   = shifted;
                bit_cnt_d = bit_cnt_q - BCW'(1);
                if (word_done) begin
                    mem_we    = 1'b1;
                    shift_d   = '0;
                    bit_cnt_d = BIT_LAST;
                    widx_d    = widx_q + AW'(1);
                    if (last_word) begin
                        state_d = DONE;
                        fill_d  = len_q;
                    end
                end
                // The edge completing the final word wins over an abort.
                if (op_abort && !(word_done && last_word)) begin
                    mem_we  = 1'b0;
                    shift_d = '0;
                    fill_d  = widx_q;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end

            READ: begin
                if (len_q == '0) begin
                    state_d = DONE;
                end else begin
                    pout_d = mem[widx_q[MAW-1:0]];
                    pval_d = 1'b1;
                    widx_d = widx_q + AW'(1);
                    if (last_word) begin
                        state_d = DONE;
                    end else if (op_abort) begin
                        pout_d  = pout_q;
                        pval_d  = 1'b0;
                        widx_d  = widx_q;
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end

            DONE: begin
                pval_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            len_q     <= '0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            widx_q    <= '0;
            fill_q    <= '0;
            pout_q    <= '0;
            pval_q    <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            widx_q    <= widx_d;
            fill_q    <= fill_d;
            pout_q    <= pout_d;
            pval_q    <= pval_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

    // Memory keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[widx_q[MAW-1:0]] <= shifted;
        end
    end

    assign pout      = pout_q;
    assign pout_val  = pval_q;
    assign scaning   = (state_q == SCAN);
    assign op_ack    = ack_q;
    assign op_commit = (state_q == DONE);
    assign op_err    = err_q;
    assign fill_cnt  = fill_q;

endmodule
